// File: rtl/eth_mdio_poll.sv
`default_nettype none
// ============================================================================
// Module   : eth_mdio_poll
// Purpose  : MDIO transaction sequencer in the MDC domain. Issues a one-shot
//            BMCR (reg 0) write on request, then polls BMSR (reg 1) at a
//            fixed interval, captures status and flags link changes.
// Options  : ETH_MDIO_POLL_TIMEOUT_EN enables a per-transaction watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module eth_mdio_poll #(
   parameter logic [4:0]  PHY_ADDR       = 5'h01,
   parameter logic [19:0] POLL_INTERVAL  = 20'd10000,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Poll_En,
   input  logic        Init_Req,
   input  logic [15:0] Init_Dat,
   input  logic        MDIO_Busy,
   input  logic        MDIO_Data_Valid,
   input  logic [5:0]  MDIO_Reg_Addr_In,
   input  logic [31:0] MDIO_Data_In,
   output logic [4:0]  MDIO_Phy_Addr,
   output logic [4:0]  MDIO_Reg_Addr,
   output logic        MDIO_Transc_Type,
   output logic        MDIO_En,
   output logic [15:0] MDIO_Wr_Dat,
   output logic [15:0] Status_Reg,
   output logic        Status_Valid,
   output logic        Link_Up,
   output logic        Link_Change,
   output logic        Poll_Busy,
   output logic        Timeout_Err
);

   localparam logic [2:0] c_StIdle       = 3'd0;
   localparam logic [2:0] c_StIssue      = 3'd1;
   localparam logic [2:0] c_StWaitAccept = 3'd2;
   localparam logic [2:0] c_StWaitDone   = 3'd3;
   localparam logic [2:0] c_StGap        = 3'd4;

   logic [2:0]  r_state;
   logic [2:0]  w_nextState;
   logic        r_initPend;
   logic [15:0] r_initDat;
   logic        r_pollPend;
   logic [19:0] r_pollCnt;
   logic        r_busyDly;
   logic        w_initPendEff;
   logic [15:0] w_initDatEff;
   logic        w_pollWrap;
   logic        w_busyFall;
   logic        w_waiting;
   logic        w_capture;
   logic        w_timeout;
   logic        w_loadInit;
   logic        w_loadPoll;
   logic        w_enNext;
   logic        w_unusedBits;

   // A request arriving this cycle is visible to IDLE immediately, so the
   // enable rises two cycles after the request pulse.
   assign w_initPendEff = r_initPend | Init_Req;
   assign w_initDatEff  = Init_Req ? Init_Dat : r_initDat;
   assign w_pollWrap    = Poll_En && (r_pollCnt == POLL_INTERVAL - 20'd1);
   assign w_busyFall    = r_busyDly & ~MDIO_Busy;
   assign w_waiting     = (r_state == c_StWaitAccept) || (r_state == c_StWaitDone);
   assign w_capture     = (r_state == c_StWaitDone) && MDIO_Data_Valid &&
                          (MDIO_Reg_Addr_In == 6'd1) && !w_timeout;

`ifdef ETH_MDIO_POLL_TIMEOUT_EN
   logic [15:0] r_wdog;

   // Watchdog: cleared in ISSUE, counts while waiting on the engine
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_wdog      <= 16'd0;
         Timeout_Err <= 1'b0;
      end else begin
         if (r_state == c_StIssue)
            r_wdog <= 16'd0;
         else if (w_waiting)
            r_wdog <= r_wdog + 16'd1;
         Timeout_Err <= w_timeout;
      end
   end

   assign w_timeout    = w_waiting && (r_wdog == TIMEOUT_CYCLES);
   assign w_unusedBits = ^MDIO_Data_In[31:16];
`else
   assign w_timeout    = 1'b0;
   assign Timeout_Err  = 1'b0;
   assign w_unusedBits = ^{MDIO_Data_In[31:16], TIMEOUT_CYCLES, w_waiting};
`endif

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) r_state <= c_StIdle;
      else     r_state <= w_nextState;
   end

   // Next-state decode
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         c_StIdle:       if (w_initPendEff || r_pollPend) w_nextState = c_StIssue;
         c_StIssue:      w_nextState = c_StWaitAccept;
         c_StWaitAccept: if (w_timeout) w_nextState = c_StGap;
                         else if (MDIO_Busy) w_nextState = c_StWaitDone;
         c_StWaitDone:   if (w_timeout || w_busyFall) w_nextState = c_StGap;
         c_StGap:        w_nextState = c_StIdle;
         default:        w_nextState = c_StIdle;
      endcase
   end

   // Output/control decode: request load strobes and next enable level
   always_comb begin
      w_loadInit = 1'b0;
      w_loadPoll = 1'b0;
      w_enNext   = 1'b0;
      case (r_state)
         c_StIdle: begin
            w_loadInit = w_initPendEff;
            w_loadPoll = !w_initPendEff && r_pollPend;
         end
         c_StIssue:      w_enNext = 1'b1;
         c_StWaitAccept: w_enNext = !(MDIO_Busy || w_timeout);
         default:        w_enNext = 1'b0;
      endcase
   end

   // Pending flags and poll interval counter
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_initPend <= 1'b0;
         r_initDat  <= 16'd0;
         r_pollPend <= 1'b0;
         r_pollCnt  <= 20'd0;
      end else begin
         if (w_loadInit)    r_initPend <= 1'b0;
         else if (Init_Req) r_initPend <= 1'b1;
         if (Init_Req) r_initDat <= Init_Dat;
         if (!Poll_En) begin
            r_pollCnt  <= 20'd0;
            r_pollPend <= 1'b0;
         end else begin
            r_pollCnt <= w_pollWrap ? 20'd0 : r_pollCnt + 20'd1;
            if (w_pollWrap)      r_pollPend <= 1'b1;
            else if (w_loadPoll) r_pollPend <= 1'b0;
         end
      end
   end

   // Request outputs: loaded in IDLE only, so they hold for the whole frame
   always_ff @(posedge Clk) begin
      if (Rst) begin
         MDIO_Phy_Addr    <= PHY_ADDR;
         MDIO_Reg_Addr    <= 5'd0;
         MDIO_Transc_Type <= 1'b0;
         MDIO_Wr_Dat      <= 16'd0;
         MDIO_En          <= 1'b0;
         Poll_Busy        <= 1'b0;
         r_busyDly        <= 1'b0;
      end else begin
         MDIO_Phy_Addr <= PHY_ADDR;
         if (w_loadInit) begin
            MDIO_Reg_Addr    <= 5'd0;
            MDIO_Transc_Type <= 1'b1;
            MDIO_Wr_Dat      <= w_initDatEff;
         end else if (w_loadPoll) begin
            MDIO_Reg_Addr    <= 5'd1;
            MDIO_Transc_Type <= 1'b0;
            MDIO_Wr_Dat      <= 16'd0;
         end
         MDIO_En   <= w_enNext;
         Poll_Busy <= (w_nextState != c_StIdle);
         r_busyDly <= MDIO_Busy;
      end
   end

   // Status capture and link-change detection
   always_ff @(posedge Clk) begin
      if (Rst) begin
         Status_Reg   <= 16'd0;
         Status_Valid <= 1'b0;
         Link_Up      <= 1'b0;
         Link_Change  <= 1'b0;
      end else begin
         Link_Change <= 1'b0;
         if (w_capture) begin
            Status_Reg   <= MDIO_Data_In[15:0];
            Status_Valid <= 1'b1;
            Link_Up      <= MDIO_Data_In[2];
            Link_Change  <= (MDIO_Data_In[2] != Link_Up);
         end
      end
   end

endmodule
`default_nettype wire
